// File: rtl/cont_10_down_sync_pkg.sv
// Shared BCD constants and helpers for the decade down-counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cont_10_down_sync_pkg;

  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_ZERO = 4'd0;

  // Out-of-range digits load as 9 so the counter always starts in BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/cont_10_down_digit.sv
// One BCD digit of the down-counter: reset > load > decrement > hold.
// Latency: 1 clk edge from rst/load/dec to q.
// Backpressure: none; dec is a plain strobe from the top level.
module cont_10_down_digit
  import cont_10_down_sync_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             is_zero
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Next digit value; 0 and any corrupted value >9 both step to 9.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(d);
    end else if (dec) begin
      if ((digit_q == BCD_ZERO) || (digit_q > BCD_MAX)) begin
        digit_d = BCD_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  // Digit register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q       = digit_q;
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/cont_10_down_sync.sv
// Cascadable synchronous BCD down-counter, DIGITS decades, optional stop at zero.
// Latency: 1 clk edge from rst/load/en to q; zero and tc are combinational.
// Backpressure: none; tc feeds the next stage's en for cascading.
module cont_10_down_sync
  import cont_10_down_sync_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int STOP_AT_ZERO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] din,
  input  logic                    en,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    zero,
  output logic                    tc
);

  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] dec;
  logic              cnt_en;

  // In stop mode the count freezes at all-zero; tc still fires from en.
  assign cnt_en = en & ~((STOP_AT_ZERO != 0) & zero);

  // Borrow chain: a digit decrements when every lower digit is at zero.
  always_comb begin
    logic borrow;
    dec    = '0;
    borrow = cnt_en;
    for (int i = 0; i < DIGITS; i++) begin
      dec[i] = borrow;
      borrow = borrow & is_zero[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    cont_10_down_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .d       (din[BCD_W*i +: BCD_W]),
      .dec     (dec[i]),
      .q       (q[BCD_W*i +: BCD_W]),
      .is_zero (is_zero[i])
    );
  end

  assign zero = &is_zero;
  assign tc   = en & zero & ~load & ~rst;

endmodule

// File: tb/tb_cont_10_down_sync.sv
module tb_cont_10_down_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Main counter: 2 digits, wrapping.
  logic       m_rst = 1'b0, m_load = 1'b0, m_en = 1'b0;
  logic [7:0] m_din = 8'h00;
  logic [7:0] m_q;
  logic       m_zero, m_tc;

  // Stop-at-zero counter: 2 digits.
  logic       s_rst = 1'b0, s_load = 1'b0, s_en = 1'b0;
  logic [7:0] s_din = 8'h00;
  logic [7:0] s_q;
  logic       s_zero, s_tc;

  // Cascade of two single-digit counters.
  logic       c_rst = 1'b0, c_load = 1'b0, c_en = 1'b0;
  logic [3:0] c0_din = 4'h0, c1_din = 4'h0;
  logic [3:0] c0_q, c1_q;
  logic       c0_zero, c0_tc, c1_zero, c1_tc;

  cont_10_down_sync #(.DIGITS(2), .STOP_AT_ZERO(0)) u_main (
    .clk(clk), .rst(m_rst), .load(m_load), .din(m_din), .en(m_en),
    .q(m_q), .zero(m_zero), .tc(m_tc)
  );

  cont_10_down_sync #(.DIGITS(2), .STOP_AT_ZERO(1)) u_stop (
    .clk(clk), .rst(s_rst), .load(s_load), .din(s_din), .en(s_en),
    .q(s_q), .zero(s_zero), .tc(s_tc)
  );

  cont_10_down_sync #(.DIGITS(1), .STOP_AT_ZERO(0)) u_c0 (
    .clk(clk), .rst(c_rst), .load(c_load), .din(c0_din), .en(c_en),
    .q(c0_q), .zero(c0_zero), .tc(c0_tc)
  );

  cont_10_down_sync #(.DIGITS(1), .STOP_AT_ZERO(0)) u_c1 (
    .clk(clk), .rst(c_rst), .load(c_load), .din(c1_din), .en(c0_tc),
    .q(c1_q), .zero(c1_zero), .tc(c1_tc)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_dn [5];
  logic [7:0] exp_st [4];
  logic       exp_st_tc [4];

  initial begin
    exp_dn    = '{8'h22, 8'h21, 8'h20, 8'h19, 8'h18};
    exp_st    = '{8'h01, 8'h00, 8'h00, 8'h00};
    exp_st_tc = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset all counters from the X state.
    m_rst = 1'b1; s_rst = 1'b1; c_rst = 1'b1;
    tick();
    chk("rst_q", {8'h00, m_q}, 16'h0000);
    chk("rst_zero", {15'd0, m_zero}, 16'd1);
    chk("rst_tc", {15'd0, m_tc}, 16'd0);
    m_rst = 1'b0; s_rst = 1'b0; c_rst = 1'b0;

    // Wrap from 00 to 99, tc only in the wrapping cycle.
    m_en = 1'b1;
    #1 chk("wrap_tc_pre", {15'd0, m_tc}, 16'd1);
    tick();
    chk("wrap_q99", {8'h00, m_q}, 16'h0099);
    chk("wrap_tc_post", {15'd0, m_tc}, 16'd0);
    tick();
    chk("wrap_q98", {8'h00, m_q}, 16'h0098);
    tick();
    chk("wrap_q97", {8'h00, m_q}, 16'h0097);

    // Load 23 and count down across the tens borrow.
    m_en = 1'b0; m_load = 1'b1; m_din = 8'h23;
    tick();
    chk("load23", {8'h00, m_q}, 16'h0023);
    m_load = 1'b0; m_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("dn_tc", {15'd0, m_tc}, 16'd0);
      tick();
      chk("dn_q", {8'h00, m_q}, {8'h00, exp_dn[i]});
    end

    // Hold with en low.
    m_en = 1'b0;
    tick(); tick();
    chk("hold", {8'h00, m_q}, 16'h0018);

    // Clamping of illegal load digits.
    m_load = 1'b1; m_din = 8'hFC;
    tick();
    chk("clamp_FC", {8'h00, m_q}, 16'h0099);
    m_din = 8'h3A;
    tick();
    chk("clamp_3A", {8'h00, m_q}, 16'h0039);

    // Load wins over en on the same edge.
    m_din = 8'h05;
    tick();
    chk("load05", {8'h00, m_q}, 16'h0005);
    m_din = 8'h40; m_en = 1'b1;
    #1 chk("load_en_tc", {15'd0, m_tc}, 16'd0);
    tick();
    chk("load_beats_en", {8'h00, m_q}, 16'h0040);
    m_load = 1'b0;
    tick();
    chk("dec_40", {8'h00, m_q}, 16'h0039);

    // 10 -> 09.
    m_en = 1'b0; m_load = 1'b1; m_din = 8'h10;
    tick();
    m_load = 1'b0; m_en = 1'b1;
    tick();
    chk("dec_10", {8'h00, m_q}, 16'h0009);

    // rst mid-count overrides load and en, then counting resumes from 0.
    m_en = 1'b0; m_load = 1'b1; m_din = 8'h57;
    tick();
    m_load = 1'b1; m_din = 8'h33; m_en = 1'b1; m_rst = 1'b1;
    #1 chk("rst_tc_low", {15'd0, m_tc}, 16'd0);
    tick();
    chk("rst_mid", {8'h00, m_q}, 16'h0000);
    m_rst = 1'b0; m_load = 1'b0;
    tick();
    chk("rst_resume", {8'h00, m_q}, 16'h0099);
    m_en = 1'b0;

    // Stop-at-zero: hold at 00 while tc keeps firing.
    s_load = 1'b1; s_din = 8'h02;
    tick();
    chk("st_load", {8'h00, s_q}, 16'h0002);
    s_load = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("st_tc", {15'd0, s_tc}, {15'd0, exp_st_tc[i]});
      tick();
      chk("st_q", {8'h00, s_q}, {8'h00, exp_st[i]});
    end
    chk("st_tc_hold", {15'd0, s_tc}, 16'd1);
    chk("st_zero", {15'd0, s_zero}, 16'd1);
    s_en = 1'b0;

    // Cascade: tens=1, units=0, one enable -> 09.
    c_load = 1'b1; c1_din = 4'h1; c0_din = 4'h0;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    #1 chk("cas_tc0", {15'd0, c0_tc}, 16'd1);
    tick();
    chk("cas_q09", {8'h00, c1_q, c0_q}, 16'h0009);

    // Cascade rst at 57 with en high, then 00 -> 99.
    c_en = 1'b0; c_load = 1'b1; c1_din = 4'h5; c0_din = 4'h7;
    tick();
    chk("cas_q57", {8'h00, c1_q, c0_q}, 16'h0057);
    c_load = 1'b0; c_en = 1'b1; c_rst = 1'b1;
    tick();
    chk("cas_rst", {8'h00, c1_q, c0_q}, 16'h0000);
    c_rst = 1'b0;
    tick();
    chk("cas_wrap", {8'h00, c1_q, c0_q}, 16'h0099);
    c_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
